hpb_cfg_decode: RTL and testbench

Host configuration decoder for the strategy core. It consumes the host config stream after it has been brought onto the core clock, and writes global strategy registers directly. Per-symbol table updates go through a valid/ready write port shared with the strategy lookup logic. It also keeps saturating command and error counters for host visibility.

---
 rtl/hpb_cfg_decode.sv | 216 +++++++++++++++++++++
 tb/tb_hpb_cfg_decode.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpb_cfg_decode.sv
// Host configuration decoder: applies global strategy commands, issues per-symbol
// table writes over a valid/ready port, and keeps saturating command/error counters.
// Optional build macro HPB_CFG_TIMEOUT_EN adds a table-grant timeout.
module hpb_cfg_decode #(
    parameter int CFG_W       = 64,
    parameter int SYM_IDX_W   = 10,
    parameter int THRESH_W    = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_config_valid,
    input  logic [CFG_W-1:0]     in_config_data,
    output logic                 in_config_accept,
    output logic                 tbl_wr_valid,
    output logic [1:0]           tbl_wr_field,
    output logic [SYM_IDX_W-1:0] tbl_wr_idx,
    output logic [THRESH_W-1:0]  tbl_wr_data,
    input  logic                 tbl_wr_ready,
    output logic                 strat_enable,
    output logic [15:0]          order_limit,
    output logic [15:0]          cfg_wr_count,
    output logic [7:0]           cfg_err_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_TBL_WR = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   xfer_s;
    logic [3:0]             opcode_s;
    logic [SYM_IDX_W-1:0]   idx_s;
    logic                   tbl_load_s;
    logic [1:0]             tbl_field_s;
    logic [THRESH_W-1:0]    tbl_data_s;
    logic                   strat_load_s;
    logic                   limit_load_s;
    logic                   wr_inc_s;
    logic                   err_inc_s;
    logic                   clr_s;
    logic                   tmo_s;
    logic                   unused_bits_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    assign xfer_s        = in_config_valid && in_config_accept;
    assign opcode_s      = in_config_data[63:60];
    assign idx_s         = in_config_data[59:50];
    assign unused_bits_s = ^in_config_data[49:32];

`ifdef HPB_CFG_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    // Cycle counter for the current table request; cleared whenever not waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_s == ST_TBL_WR && state_r == ST_TBL_WR) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    assign tmo_s = (state_r == ST_TBL_WR) && (tmo_cnt_r == 8'(TIMEOUT_CYC - 1));
`else
    assign tmo_s = 1'b0;
`endif

    // Command decode and next-state selection.
    always_comb begin
        state_s      = state_r;
        tbl_load_s   = 1'b0;
        tbl_field_s  = 2'd0;
        tbl_data_s   = '0;
        strat_load_s = 1'b0;
        limit_load_s = 1'b0;
        wr_inc_s     = 1'b0;
        err_inc_s    = 1'b0;
        clr_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    case (opcode_s)
                        4'h1: begin
                            tbl_load_s  = 1'b1;
                            tbl_field_s = 2'd0;
                            tbl_data_s  = THRESH_W'(in_config_data[31:0]);
                            state_s     = ST_TBL_WR;
                        end
                        4'h2: begin
                            tbl_load_s  = 1'b1;
                            tbl_field_s = 2'd1;
                            tbl_data_s  = THRESH_W'(in_config_data[15:0]);
                            state_s     = ST_TBL_WR;
                        end
                        4'h3: begin
                            tbl_load_s  = 1'b1;
                            tbl_field_s = 2'd2;
                            tbl_data_s  = THRESH_W'(in_config_data[0]);
                            state_s     = ST_TBL_WR;
                        end
                        4'h8: begin
                            strat_load_s = 1'b1;
                            wr_inc_s     = 1'b1;
                        end
                        4'h9: begin
                            clr_s = 1'b1;
                        end
                        4'hA: begin
                            limit_load_s = 1'b1;
                            wr_inc_s     = 1'b1;
                        end
                        default: begin
                            err_inc_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TBL_WR: begin
                // A grant coinciding with the timeout still counts as success.
                if (tbl_wr_ready) begin
                    state_s  = ST_IDLE;
                    wr_inc_s = 1'b1;
                end else if (tmo_s) begin
                    state_s   = ST_IDLE;
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_TBL_WR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            in_config_accept <= 1'b0;
            tbl_wr_valid     <= 1'b0;
        end else begin
            state_r          <= state_s;
            in_config_accept <= (state_s == ST_IDLE);
            tbl_wr_valid     <= (state_s == ST_TBL_WR);
        end
    end

    // Table request fields, held stable for the whole request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_wr_field <= 2'd0;
            tbl_wr_idx   <= '0;
            tbl_wr_data  <= '0;
        end else if (tbl_load_s) begin
            tbl_wr_field <= tbl_field_s;
            tbl_wr_idx   <= idx_s;
            tbl_wr_data  <= tbl_data_s;
        end
    end

    // Global strategy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strat_enable <= 1'b0;
            order_limit  <= 16'd0;
        end else begin
            if (strat_load_s) begin
                strat_enable <= in_config_data[0];
            end
            if (limit_load_s) begin
                order_limit <= in_config_data[15:0];
            end
        end
    end

    // Saturating host-visible counters; clear takes precedence and is itself uncounted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_wr_count  <= 16'd0;
            cfg_err_count <= 8'd0;
        end else if (clr_s) begin
            cfg_wr_count  <= 16'd0;
            cfg_err_count <= 8'd0;
        end else begin
            if (wr_inc_s) begin
                cfg_wr_count <= sat_inc16(cfg_wr_count);
            end
            if (err_inc_s) begin
                cfg_err_count <= sat_inc8(cfg_err_count);
            end
        end
    end

endmodule

// File: tb/tb_hpb_cfg_decode.sv
// Scoreboard bench for hpb_cfg_decode: stimulus pushes hand-computed expectations,
// a monitor pops them on each global transfer and on each table-write grant.
module tb_hpb_cfg_decode;

    logic        clk;
    logic        reset_n;
    logic        in_config_valid;
    logic [63:0] in_config_data;
    logic        in_config_accept;
    logic        tbl_wr_valid;
    logic [1:0]  tbl_wr_field;
    logic [9:0]  tbl_wr_idx;
    logic [31:0] tbl_wr_data;
    logic        tbl_wr_ready;
    logic        strat_enable;
    logic [15:0] order_limit;
    logic [15:0] cfg_wr_count;
    logic [7:0]  cfg_err_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        strat;
        logic [15:0] lim;
        logic [15:0] wr;
        logic [7:0]  err;
    } gexp_t;

    typedef struct {
        logic [9:0]  idx;
        logic [1:0]  field;
        logic [31:0] data;
        logic [15:0] wr;
        logic [7:0]  err;
    } texp_t;

    gexp_t gq[$];
    texp_t tq[$];

    hpb_cfg_decode dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_config_valid  (in_config_valid),
        .in_config_data   (in_config_data),
        .in_config_accept (in_config_accept),
        .tbl_wr_valid     (tbl_wr_valid),
        .tbl_wr_field     (tbl_wr_field),
        .tbl_wr_idx       (tbl_wr_idx),
        .tbl_wr_data      (tbl_wr_data),
        .tbl_wr_ready     (tbl_wr_ready),
        .strat_enable     (strat_enable),
        .order_limit      (order_limit),
        .cfg_wr_count     (cfg_wr_count),
        .cfg_err_count    (cfg_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one word; returns at the negedge following the transfer edge.
    task automatic send(input logic [63:0] w);
        int n;
        n = 0;
        in_config_valid = 1'b1;
        in_config_data  = w;
        while (!in_config_accept && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_wait_timeout", 64'd1, 64'd0);
        end
        @(negedge clk);
        in_config_valid = 1'b0;
    endtask

    task automatic send_glob(input logic [63:0] w, input logic s, input logic [15:0] l,
                             input logic [15:0] wr, input logic [7:0] er);
        gexp_t g;
        g.strat = s; g.lim = l; g.wr = wr; g.err = er;
        gq.push_back(g);
        send(w);
    endtask

    task automatic send_tbl(input logic [63:0] w, input logic [9:0] i, input logic [1:0] f,
                            input logic [31:0] d, input logic [15:0] wr, input logic [7:0] er);
        texp_t t;
        t.idx = i; t.field = f; t.data = d; t.wr = wr; t.err = er;
        tq.push_back(t);
        send(w);
    endtask

    // Monitor: routes each global transfer and each table grant to its scoreboard queue.
    initial begin
        logic       xf;
        logic       gr;
        logic       have_t;
        logic [3:0] opc;
        gexp_t      g;
        texp_t      t;
        forever begin
            @(posedge clk);
            xf     = in_config_valid && in_config_accept && reset_n;
            opc    = in_config_data[63:60];
            gr     = tbl_wr_valid && tbl_wr_ready && reset_n;
            have_t = 1'b0;
            if (gr) begin
                if (tq.size() == 0) begin
                    chk("unexpected_grant", 64'd1, 64'd0);
                end else begin
                    t = tq.pop_front();
                    have_t = 1'b1;
                    chk("tbl_idx", 64'(tbl_wr_idx), 64'(t.idx));
                    chk("tbl_field", 64'(tbl_wr_field), 64'(t.field));
                    chk("tbl_data", 64'(tbl_wr_data), 64'(t.data));
                end
            end
            @(negedge clk);
            if (xf && !(opc inside {4'h1, 4'h2, 4'h3})) begin
                if (gq.size() == 0) begin
                    chk("unexpected_global", 64'd1, 64'd0);
                end else begin
                    g = gq.pop_front();
                    chk("strat_enable", 64'(strat_enable), 64'(g.strat));
                    chk("order_limit", 64'(order_limit), 64'(g.lim));
                    chk("glob_wr_count", 64'(cfg_wr_count), 64'(g.wr));
                    chk("glob_err_count", 64'(cfg_err_count), 64'(g.err));
                end
            end
            if (have_t) begin
                chk("tbl_wr_count", 64'(cfg_wr_count), 64'(t.wr));
                chk("tbl_err_count", 64'(cfg_err_count), 64'(t.err));
                chk("tbl_valid_drop", 64'(tbl_wr_valid), 64'd0);
                chk("tbl_accept_rise", 64'(in_config_accept), 64'd1);
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        in_config_valid = 1'b0;
        in_config_data  = 64'd0;
        tbl_wr_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_accept", 64'(in_config_accept), 64'd0);
        chk("rst_valid", 64'(tbl_wr_valid), 64'd0);
        chk("rst_outputs", {tbl_wr_data, tbl_wr_idx, tbl_wr_field, strat_enable, order_limit},
            64'd0);
        chk("rst_counters", {cfg_wr_count, cfg_err_count}, 64'd0);
        reset_n = 1'b1;
        chk("accept_low_at_release", 64'(in_config_accept), 64'd0);
        @(posedge clk); #1;
        chk("accept_after_release", 64'(in_config_accept), 64'd1);
        @(negedge clk);

        send_glob(64'h8000_0000_0000_0001, 1'b1, 16'd0, 16'd1, 8'd0);

        // Threshold write, grant delayed: valid held 4 cycles with stable fields.
        send_tbl(64'h1014_0000_1234_5678, 10'd5, 2'd0, 32'h1234_5678, 16'd2, 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk("tw_valid_hold", 64'(tbl_wr_valid), 64'd1);
            chk("tw_accept_low", 64'(in_config_accept), 64'd0);
            chk("tw_wr_count_hold", 64'(cfg_wr_count), 64'd1);
            @(negedge clk);
        end
        tbl_wr_ready = 1'b1;
        chk("tw_valid_4th", 64'(tbl_wr_valid), 64'd1);
        @(negedge clk);

        // Ready held high: grant on the cycle right after transfer, still 2 cycles/op.
        send_tbl(64'h2FFF_0000_1234_ABCD, 10'h3FF, 2'd1, 32'h0000_ABCD, 16'd3, 8'd0);
        chk("min2_valid", 64'(tbl_wr_valid), 64'd1);
        chk("min2_accept", 64'(in_config_accept), 64'd0);
        send_tbl(64'h3000_0000_FFFF_FFFF, 10'd0, 2'd2, 32'h0000_0001, 16'd4, 8'd0);

        // Back-to-back global / illegal / clear with ready high while idle.
        send_glob(64'hA000_0000_0000_00C8, 1'b1, 16'd200, 16'd5, 8'd0);
        send_glob(64'hF000_0000_0000_0000, 1'b1, 16'd200, 16'd5, 8'd1);
        send_glob(64'h9000_0000_0000_0000, 1'b1, 16'd200, 16'd0, 8'd0);
        tbl_wr_ready = 1'b0;

        for (int k = 1; k <= 32'h10000; k++) begin
            send_glob(64'h8000_0000_0000_0001, 1'b1, 16'd200,
                      (k >= 32'hFFFF) ? 16'hFFFF : 16'(k), 8'd0);
        end
        for (int k = 1; k <= 256; k++) begin
            send_glob(64'h5000_0000_0000_0000, 1'b1, 16'd200, 16'hFFFF,
                      (k >= 255) ? 8'hFF : 8'(k));
        end

        // Reset during a pending table request abandons it.
        send(64'h1000_0000_0000_0007);
        chk("pre_rst_valid", 64'(tbl_wr_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(tbl_wr_valid), 64'd0);
        chk("midrst_accept", 64'(in_config_accept), 64'd0);
        chk("midrst_counters", {cfg_wr_count, cfg_err_count}, 64'd0);
        chk("midrst_globals", {strat_enable, order_limit}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("accept_after_rerelease", 64'(in_config_accept), 64'd1);
        @(negedge clk);
        send_glob(64'hA000_0000_0000_0001, 1'b0, 16'd1, 16'd1, 8'd0);

        repeat (3) @(negedge clk);
        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("tq_drained", 64'(tq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
